request_encoder: RTL and testbench

//   Sequential N-to-log2(N) request encoder: the inverse of the 2-to-4 address decoder.
//   - Captures request lines into a sticky pending register.
//   - Picks one pending request and presents its binary index with a valid/ack handshake.
//   - address[0]/address[1] drive a decoder's address0/address1, and valid drives its enable,
//     so the decoder regenerates the one-hot grant.
//   - Sits between interrupt/request sources and the decoder-driven select logic.

---
 rtl/enc_pkg.sv | 12 +
 rtl/priority_pick.sv | 42 ++++
 rtl/request_encoder.sv | 99 +++++++++
 tb/tb_request_encoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the request encoder: FSM state encoding and the
// default number of request lines.
package enc_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  localparam int REQ_W = 4;

endpackage

// File: rtl/priority_pick.sv
// Combinational request picker: rotates the request vector so that index
// `start_i` lands at bit 0, finds the first set bit, then maps that position
// back to an absolute index. Fixed-priority mode pins the start to 0.
module priority_pick
  import enc_pkg::*;
#(
  parameter  int N_REQ       = REQ_W,
  parameter  int ROUND_ROBIN = 0,
  localparam int ADDR_W      = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]  vec_i,
  input  logic [ADDR_W-1:0] start_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              any_o
);

  logic [ADDR_W-1:0]  start_eff;
  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] shifted;
  logic [N_REQ-1:0]   rot;

  assign start_eff = (ROUND_ROBIN != 0) ? start_i : '0;

  // Doubling the vector turns the rotation into a plain right shift:
  // rot[k] holds vec[(start + k) mod N_REQ].
  assign dbl     = {vec_i, vec_i};
  assign shifted = dbl >> start_eff;
  assign rot     = shifted[N_REQ-1:0];
  assign any_o   = |vec_i;

  // Find first set bit of the rotated vector; scanning high-to-low lets the
  // lowest rotated position win. The add wraps naturally modulo N_REQ.
  always_comb begin
    idx_o = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx_o = start_eff + k[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/request_encoder.sv
// Sequential N-to-log2(N) request encoder. Requests accumulate in a sticky
// pending register; one is picked and presented as a binary address with a
// valid/ack handshake, suitable for driving a decoder's address and enable.
module request_encoder
  import enc_pkg::*;
#(
  parameter  int N_REQ       = REQ_W,
  parameter  int ROUND_ROBIN = 0,
  localparam int ADDR_W      = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [N_REQ-1:0]  req,
  input  logic              ack,
  output logic              valid,
  output logic [ADDR_W-1:0] address,
  output logic [N_REQ-1:0]  pending
);

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [N_REQ-1:0]  clr;
  logic [N_REQ-1:0]  cand;
  logic [ADDR_W-1:0] start;
  logic [ADDR_W-1:0] pick_idx;
  logic              pick_any;

  // Requests arriving this cycle are eligible immediately, giving one-cycle
  // latency from req to valid.
  assign cand  = pend_q | req;
  assign start = last_q + ADDR_W'(1);

  priority_pick #(
    .N_REQ       (N_REQ),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .vec_i   (cand),
    .start_i (start),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Next-state logic: grant from IDLE, release on ack; the pending update
  // clears the granted bit first and then ORs new requests, so a same-index
  // request in the ack cycle survives.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    last_d  = last_q;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable && pick_any) begin
          state_d = ST_PRESENT;
          valid_d = 1'b1;
          addr_d  = pick_idx;
        end
      end
      ST_PRESENT: begin
        if (ack) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          last_d  = addr_q;
          clr     = N_REQ'(1) << addr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pend_d = (pend_q & ~clr) | (enable ? req : '0);
  end

  // State, output and pending registers with synchronous active-low reset;
  // rotation restarts at index 0 because last grant resets to N_REQ-1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      last_q  <= ADDR_W'(N_REQ - 1);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  assign valid   = valid_q;
  assign address = addr_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_request_encoder.sv
// Bench for request_encoder: a fixed-priority and a round-robin instance share
// the same stimulus; a behavioural model tracks both and is compared every
// cycle, alongside hand-computed expectations for the directed scenarios.
module tb_request_encoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] req;
  logic       ack;

  logic       v0, v1;
  logic [1:0] a0, a1;
  logic [3:0] p0, p1;

  int checks = 0;
  int errors = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  request_encoder #(.N_REQ(4), .ROUND_ROBIN(0)) dut_fp (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .req     (req),
    .ack     (ack),
    .valid   (v0),
    .address (a0),
    .pending (p0)
  );

  request_encoder #(.N_REQ(4), .ROUND_ROBIN(1)) dut_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .req     (req),
    .ack     (ack),
    .valid   (v1),
    .address (a1),
    .pending (p1)
  );

  // Behavioural model: index 0 = fixed priority, index 1 = round robin.
  logic       mv [2];
  logic [1:0] ma [2];
  logic [3:0] mp [2];
  int         ml [2];
  logic [3:0] mcand, mnp;

  function automatic int pick(input logic [3:0] c, input int rr, input int last);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (rr != 0) ? (last + 1 + k) % 4 : k;
      if (c[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        mv[d] = 1'b0;
        ma[d] = 2'd0;
        mp[d] = 4'd0;
        ml[d] = 3;
      end else begin
        mcand = mp[d] | req;
        mnp   = mp[d];
        if (mv[d] && ack) mnp[ma[d]] = 1'b0;
        if (enable) mnp = mnp | req;
        if (mv[d]) begin
          if (ack) begin
            mv[d] = 1'b0;
            ml[d] = int'(ma[d]);
          end
        end else if (enable && mcand != 4'd0) begin
          ma[d] = 2'(pick(mcand, d, ml[d]));
          mv[d] = 1'b1;
        end
        mp[d] = mnp;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("fp valid", 32'(v0), 32'(mv[0]));
      check("fp pending", 32'(p0), 32'(mp[0]));
      if (mv[0]) check("fp address", 32'(a0), 32'(ma[0]));
      check("rr valid", 32'(v1), 32'(mv[1]));
      check("rr pending", 32'(p1), 32'(mp[1]));
      if (mv[1]) check("rr address", 32'(a1), 32'(ma[1]));
    end
  end

  // Apply inputs just after a falling edge, return at the next falling edge.
  task automatic step(input logic rn, input logic en, input logic [3:0] r, input logic a);
    reset_n = rn;
    enable  = en;
    req     = r;
    ack     = a;
    @(negedge clk);
  endtask

  int exp_seq [5] = '{0, 1, 2, 3, 0};
  logic [3:0] dec;

  initial begin
    int n;
    int cyc;
    logic prevv;

    reset_n = 1'b0;
    enable  = 1'b1;
    req     = 4'b1111;
    ack     = 1'b0;
    @(negedge clk);
    step(1'b0, 1'b1, 4'b1111, 1'b0);
    chk_on = 1'b1;

    // Reset state
    check("reset valid", 32'(v0), 0);
    check("reset address", 32'(a0), 0);
    check("reset pending", 32'(p0), 0);
    check("reset rr valid", 32'(v1), 0);

    // Single request, decoder view
    step(1'b1, 1'b1, 4'b0100, 1'b0);
    check("single valid", 32'(v0), 1);
    check("single address", 32'(a0), 2);
    check("single pending", 32'(p0), 32'h4);
    dec = v0 ? (4'b0001 << a0) : 4'b0000;
    check("single decoder", 32'(dec), 32'h4);
    check("single rr address", 32'(a1), 2);
    step(1'b1, 1'b1, 4'b0000, 1'b1);
    check("single ack valid", 32'(v0), 0);
    check("single ack pending", 32'(p0), 0);

    // Fixed priority ordering
    step(1'b1, 1'b1, 4'b1010, 1'b0);
    check("fixed first", 32'(a0), 1);
    check("rr after 2 picks 3", 32'(a1), 3);
    step(1'b1, 1'b1, 4'b0000, 1'b1);
    check("fixed idle gap", 32'(v0), 0);
    check("fixed remaining", 32'(p0), 32'h8);
    step(1'b1, 1'b1, 4'b0000, 1'b0);
    check("fixed second valid", 32'(v0), 1);
    check("fixed second", 32'(a0), 3);
    step(1'b1, 1'b1, 4'b0000, 1'b1);
    check("fixed drained", 32'(p0), 0);

    // Round robin with all requests held and ack whenever valid
    step(1'b0, 1'b1, 4'b0000, 1'b0);
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 40) begin
      prevv = v1;
      step(1'b1, 1'b1, 4'b1111, v1);
      cyc++;
      if (prevv) check("rr gap", 32'(v1), 0);
      else if (v1) begin
        check($sformatf("rr grant %0d", n), 32'(a1), 32'(exp_seq[n]));
        n++;
      end
    end
    if (n < 5) check("rr timeout grants", 32'(n), 5);
    step(1'b1, 1'b1, 4'b0000, 1'b1);

    // Enable gating
    step(1'b0, 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b0001, 1'b0);
    check("gated valid", 32'(v0), 0);
    check("gated pending", 32'(p0), 0);
    step(1'b1, 1'b1, 4'b0001, 1'b0);
    check("enabled valid", 32'(v0), 1);
    check("enabled address", 32'(a0), 0);
    check("enabled rr address", 32'(a1), 0);
    step(1'b1, 1'b1, 4'b0000, 1'b1);

    // Same-index ack and request race, then reset during a grant
    step(1'b0, 1'b1, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 4'b0100, 1'b0);
    check("race grant", 32'(a0), 2);
    step(1'b1, 1'b1, 4'b0100, 1'b1);
    check("race idle", 32'(v0), 0);
    check("race pending kept", 32'(p0[2]), 1);
    step(1'b1, 1'b1, 4'b0000, 1'b0);
    check("race regrant valid", 32'(v0), 1);
    check("race regrant address", 32'(a0), 2);
    step(1'b0, 1'b1, 4'b0000, 1'b0);
    check("mid reset valid", 32'(v0), 0);
    check("mid reset pending", 32'(p0), 0);
    check("mid reset rr valid", 32'(v1), 0);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
